data_cache: RTL and testbench
=============================

Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the single-cycle RV32i core's data port (address, write data, write enable, read data) and the slower external data memory.
- Hits complete in zero wait cycles.
- Misses and all writes stall the core while a request/acknowledge handshake with memory completes.
- Also keeps saturating hit/miss counters for the memory-system lab measurements.

Parameters:
- LINES, 16, number of one-word lines; power of two, 2..256.
- ADDR_W, 16, byte-address width, matching the core's 16-bit data address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  core performs a data access this cycle.
- cpu_we  in  1  1 = store, 0 = load; valid with cpu_req.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored (word access only).
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; combinational from the line array.
- stall  out  1  core must hold PC and all request inputs while 1.
- flush  in  1  invalidate all lines.
- mem_req  out  1  registered request to memory.
- mem_we  out  1  registered; 1 = write.
- mem_addr  out  ADDR_W  registered word-aligned address.
- mem_wdata  out  32  registered write data.
- mem_ack  in  1  memory completes the current request this cycle.
- mem_rdata  in  32  read data, valid with mem_ack.
- hit_cnt  out  16  load hits, saturating at 16'hFFFF.
- miss_cnt  out  16  load misses, saturating at 16'hFFFF.

Behaviour:
- Address split:
  - IDX_W = log2(LINES).
  - index = cpu_addr[IDX_W+1:2].
  - tag = cpu_addr[ADDR_W-1:IDX_W+2].
  - Each line holds valid, tag and data.
- hit = cpu_req & valid[index] & (tag[index] == tag).
- cpu_rdata = data[index] at all times; 0 when the line is invalid.
- Reset (async, rst = 0):
  - state = IDLE; all valid bits = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - hit_cnt = 0, miss_cnt = 0.
  - An in-flight memory request is abandoned; mem_req drops immediately.
- States: IDLE, RMISS, WTHRU, DONE.
- IDLE:
  - flush = 1: clear all valid bits at the edge; stall = 1 if cpu_req; stay in IDLE. Flush has priority over a simultaneous cpu_req, which is handled next cycle and then misses.
  - Load hit: stall = 0; hit_cnt++; stay in IDLE.
  - Load miss: stall = 1; miss_cnt++; latch word address; at the edge set mem_req = 1, mem_we = 0; go to RMISS.
  - Store, hit or miss: stall = 1; at the edge set mem_req = 1, mem_we = 1, mem_addr, mem_wdata = cpu_wdata; go to WTHRU.
    - On a hit, the line's data is updated at the same edge.
    - On a miss, no allocation.
  - No cpu_req: stall = 0; nothing happens.
- RMISS:
  - stall = 1; mem_* held stable until mem_ack.
  - On mem_ack: write the line (valid = 1, tag, data = mem_rdata), mem_req = 0, go to IDLE. The held load then hits.
  - The refill hit also increments hit_cnt.
- WTHRU:
  - stall = 1; outputs held.
  - On mem_ack: mem_req = 0, mem_we = 0, go to DONE.
- DONE:
  - stall = 0; the held store retires at this edge.
  - cpu_req is ignored (not re-issued, not counted); go to IDLE.
- flush outside IDLE: ignored. The requester holds it until it is observed in IDLE.
- mem_ack outside RMISS/WTHRU: ignored.
- Latency with mem_ack on the first cycle mem_req is high:
  - Load miss: 2 stall cycles, data delivered in the 3rd cycle.
  - Store: 2 stall cycles, retires in the 3rd (DONE) cycle.
- Each extra cycle without mem_ack adds one stall cycle.
- Counter saturation: at 16'hFFFF the count holds; there is no wrap.

Test Plan:
- Reset, then load 0x0040 with memory returning 0xDEADBEEF, ack 1 cycle after mem_req:
  - Stall is 1 for exactly 2 cycles.
  - mem_addr = 0x0040, mem_we = 0.
  - cpu_rdata = 0xDEADBEEF in cycle 3.
  - miss_cnt = 1, hit_cnt = 1.
- Repeat load 0x0040: stall = 0, no mem_req, cpu_rdata = 0xDEADBEEF, hit_cnt = 2.
- Store 0x12345678 to 0x0040 with ack after 3 wait cycles:
  - mem_req held for 4 cycles with mem_we = 1, mem_wdata = 0x12345678.
  - DONE cycle has stall = 0.
  - A following load of 0x0040 hits with 0x12345678.
- Store to 0x0080 (miss, no allocate), then load 0x0080: the load misses and a read request is issued.
- Conflict: load 0x0040, then load 0x0440 (same index 0, different tag):
  - The second load misses and replaces the line.
  - Reloading 0x0040 misses again; miss_cnt increments each time.
- Flush asserted together with a load of 0x0040 after it is cached: stall = 1 that cycle, and the next cycle misses. Separately, drive rst low while in RMISS: mem_req drops asynchronously and all counters read 0.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the RV32i data port.
// Hits return combinationally; misses and all stores stall the core across a req/ack memory handshake.
module data_cache #(
    parameter int LINES  = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              stall,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic [1:0] {S_IDLE, S_RMISS, S_WTHRU, S_DONE} state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [15:0]       r_hit_cnt;
    logic [15:0]       r_miss_cnt;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_fidx;
    logic [TAG_W-1:0] w_ftag;
    logic             w_hit;
    logic             w_rd_start;
    logic             w_wr_start;
    logic             w_wr_hit;
    logic             w_fill;
    logic             w_wr_done;
    logic             w_flush;
    logic             w_hit_inc;
    logic             w_miss_inc;
    logic             w_unused_lsb;

    assign w_idx        = cpu_addr[IDX_W+1:2];
    assign w_tag        = cpu_addr[ADDR_W-1:IDX_W+2];
    assign w_unused_lsb = ^cpu_addr[1:0];

    // Refill targets the latched miss address, not the live core address.
    assign w_fidx = r_mem_addr[IDX_W+1:2];
    assign w_ftag = r_mem_addr[ADDR_W-1:IDX_W+2];

    assign w_hit     = cpu_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign cpu_rdata = r_valid[w_idx] ? r_data[w_idx] : 32'h0;

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        stall      = 1'b0;
        w_rd_start = 1'b0;
        w_wr_start = 1'b0;
        w_wr_hit   = 1'b0;
        w_fill     = 1'b0;
        w_wr_done  = 1'b0;
        w_flush    = 1'b0;
        w_hit_inc  = 1'b0;
        w_miss_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    w_flush = 1'b1;
                    stall   = cpu_req;
                end else if (cpu_req) begin
                    if (cpu_we) begin
                        stall      = 1'b1;
                        w_wr_start = 1'b1;
                        w_wr_hit   = w_hit;
                        w_state_nx = S_WTHRU;
                    end else if (w_hit) begin
                        w_hit_inc = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        w_miss_inc = 1'b1;
                        w_rd_start = 1'b1;
                        w_state_nx = S_RMISS;
                    end
                end
            end
            S_RMISS: begin
                stall = 1'b1;
                if (mem_ack) begin
                    w_fill     = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            S_WTHRU: begin
                stall = 1'b1;
                if (mem_ack) begin
                    w_wr_done  = 1'b1;
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_rd_start) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {cpu_addr[ADDR_W-1:2], 2'b00};
        end else if (w_wr_start) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
            r_mem_wdata <= cpu_wdata;
        end else if (w_fill) begin
            r_mem_req <= 1'b0;
        end else if (w_wr_done) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (w_flush) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_fidx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_fidx]  <= w_ftag;
            r_data[w_fidx] <= mem_rdata;
        end else if (w_wr_hit) begin
            r_data[w_idx] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit_inc && r_hit_cnt != 16'hFFFF)
                r_hit_cnt <= r_hit_cnt + 16'd1;
            if (w_miss_inc && r_miss_cnt != 16'hFFFF)
                r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache: miss/hit latency, write-through, conflicts, flush and async reset.
module tb_data_cache;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int check_cnt = 0;
    int pass_cnt  = 0;

    int          n_stall;
    int          n_req;
    logic [31:0] got;
    logic        s_we;
    logic [15:0] s_addr;
    logic [31:0] s_wdata;
    logic        to;

    data_cache #(.LINES(16), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .stall(stall), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one core access from a negedge; memory acks after `waits` cycles of mem_req.
    // Returns at a negedge with the access retired and cpu_req low.
    task automatic access(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                          input int waits, input logic [31:0] rd,
                          output int ns, output int nr, output logic [31:0] g,
                          output logic swe, output logic [15:0] sad, output logic [31:0] swd,
                          output logic tmo);
        int k;
        ns = 0; nr = 0; g = 32'h0; swe = 1'b0; sad = 16'h0; swd = 32'h0; tmo = 1'b1; k = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        for (int c = 0; c < 40; c++) begin
            #1;
            mem_ack = 1'b0;
            if (mem_req) begin
                nr++;
                swe = mem_we; sad = mem_addr; swd = mem_wdata;
                if (k == waits) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd;
                end
                k++;
            end
            if (!stall) begin
                g = cpu_rdata;
                tmo = 1'b0;
                break;
            end
            ns++;
            @(negedge clk);
        end
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 32'h0;
        flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check_cnt++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", mem_req); else pass_cnt++;
        check_cnt++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we); else pass_cnt++;
        check_cnt++; if (mem_addr !== 16'h0) $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); else pass_cnt++;
        check_cnt++; if (mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); else pass_cnt++;
        check_cnt++; if (hit_cnt !== 16'h0) $display("FAIL rst_hit_cnt: got %0d want 0", hit_cnt); else pass_cnt++;
        check_cnt++; if (miss_cnt !== 16'h0) $display("FAIL rst_miss_cnt: got %0d want 0", miss_cnt); else pass_cnt++;
        check_cnt++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else pass_cnt++;
        check_cnt++; if (cpu_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", cpu_rdata); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_load_miss();
        access(1'b0, 16'h0040, 32'h0, 0, 32'hDEADBEEF, n_stall, n_req, got, s_we, s_addr, s_wdata, to);
        check_cnt++; if (to !== 1'b0 || n_stall !== 2) $display("FAIL ldmiss_stall: got %0d (timeout %b) want 2", n_stall, to); else pass_cnt++;
        check_cnt++; if (n_req !== 1) $display("FAIL ldmiss_req_cycles: got %0d want 1", n_req); else pass_cnt++;
        check_cnt++; if (s_addr !== 16'h0040) $display("FAIL ldmiss_addr: got %h want 0040", s_addr); else pass_cnt++;
        check_cnt++; if (s_we !== 1'b0) $display("FAIL ldmiss_we: got %b want 0", s_we); else pass_cnt++;
        check_cnt++; if (got !== 32'hDEADBEEF) $display("FAIL ldmiss_rdata: got %h want deadbeef", got); else pass_cnt++;
        check_cnt++; if (miss_cnt !== 16'd1) $display("FAIL ldmiss_miss_cnt: got %0d want 1", miss_cnt); else pass_cnt++;
        check_cnt++; if (hit_cnt !== 16'd1) $display("FAIL ldmiss_hit_cnt: got %0d want 1", hit_cnt); else pass_cnt++;
    endtask

    task automatic test_load_hit();
        access(1'b0, 16'h0040, 32'h0, 0, 32'hFFFFFFFF, n_stall, n_req, got, s_we, s_addr, s_wdata, to);
        check_cnt++; if (to !== 1'b0 || n_stall !== 0) $display("FAIL ldhit_stall: got %0d (timeout %b) want 0", n_stall, to); else pass_cnt++;
        check_cnt++; if (n_req !== 0) $display("FAIL ldhit_req: got %0d want 0", n_req); else pass_cnt++;
        check_cnt++; if (got !== 32'hDEADBEEF) $display("FAIL ldhit_rdata: got %h want deadbeef", got); else pass_cnt++;
        check_cnt++; if (hit_cnt !== 16'd2) $display("FAIL ldhit_hit_cnt: got %0d want 2", hit_cnt); else pass_cnt++;
        check_cnt++; if (miss_cnt !== 16'd1) $display("FAIL ldhit_miss_cnt: got %0d want 1", miss_cnt); else pass_cnt++;
    endtask

    task automatic test_store_hit();
        access(1'b1, 16'h0040, 32'h12345678, 3, 32'h0, n_stall, n_req, got, s_we, s_addr, s_wdata, to);
        check_cnt++; if (to !== 1'b0 || n_stall !== 5) $display("FAIL sthit_stall: got %0d (timeout %b) want 5", n_stall, to); else pass_cnt++;
        check_cnt++; if (n_req !== 4) $display("FAIL sthit_req_cycles: got %0d want 4", n_req); else pass_cnt++;
        check_cnt++; if (s_we !== 1'b1) $display("FAIL sthit_we: got %b want 1", s_we); else pass_cnt++;
        check_cnt++; if (s_wdata !== 32'h12345678) $display("FAIL sthit_wdata: got %h want 12345678", s_wdata); else pass_cnt++;
        check_cnt++; if (s_addr !== 16'h0040) $display("FAIL sthit_addr: got %h want 0040", s_addr); else pass_cnt++;
        check_cnt++; if (hit_cnt !== 16'd2 || miss_cnt !== 16'd1) $display("FAIL sthit_cnts: got %0d/%0d want 2/1", hit_cnt, miss_cnt); else pass_cnt++;
        access(1'b0, 16'h0040, 32'h0, 0, 32'hFFFFFFFF, n_stall, n_req, got, s_we, s_addr, s_wdata, to);
        check_cnt++; if (to !== 1'b0 || n_stall !== 0) $display("FAIL sthit_reload_stall: got %0d want 0", n_stall); else pass_cnt++;
        check_cnt++; if (got !== 32'h12345678) $display("FAIL sthit_reload_rdata: got %h want 12345678", got); else pass_cnt++;
        check_cnt++; if (hit_cnt !== 16'd3) $display("FAIL sthit_reload_hit_cnt: got %0d want 3", hit_cnt); else pass_cnt++;
    endtask

    task automatic test_store_miss();
        // 0x0080 shares index 0 with 0x0040 but has another tag.
        access(1'b1, 16'h0080, 32'hCAFEF00D, 0, 32'h0, n_stall, n_req, got, s_we, s_addr, s_wdata, to);
        check_cnt++; if (to !== 1'b0 || n_stall !== 2) $display("FAIL stmiss_stall: got %0d want 2", n_stall); else pass_cnt++;
        check_cnt++; if (n_req !== 1) $display("FAIL stmiss_req: got %0d want 1", n_req); else pass_cnt++;
        check_cnt++; if (s_addr !== 16'h0080 || s_we !== 1'b1) $display("FAIL stmiss_addr_we: got %h/%b want 0080/1", s_addr, s_we); else pass_cnt++;
        check_cnt++; if (got !== 32'h12345678) $display("FAIL stmiss_no_alloc: got %h want 12345678", got); else pass_cnt++;
        access(1'b0, 16'h0080, 32'h0, 1, 32'h0BADF00D, n_stall, n_req, got, s_we, s_addr, s_wdata, to);
        check_cnt++; if (to !== 1'b0 || n_stall !== 3) $display("FAIL stmiss_ld_stall: got %0d want 3", n_stall); else pass_cnt++;
        check_cnt++; if (n_req !== 2 || s_we !== 1'b0) $display("FAIL stmiss_ld_req: got %0d/%b want 2/0", n_req, s_we); else pass_cnt++;
        check_cnt++; if (s_addr !== 16'h0080) $display("FAIL stmiss_ld_addr: got %h want 0080", s_addr); else pass_cnt++;
        check_cnt++; if (got !== 32'h0BADF00D) $display("FAIL stmiss_ld_rdata: got %h want 0badf00d", got); else pass_cnt++;
        check_cnt++; if (miss_cnt !== 16'd2 || hit_cnt !== 16'd4) $display("FAIL stmiss_cnts: got %0d/%0d want 2/4", miss_cnt, hit_cnt); else pass_cnt++;
    endtask

    task automatic test_conflict();
        access(1'b0, 16'h0040, 32'h0, 0, 32'h11111111, n_stall, n_req, got, s_we, s_addr, s_wdata, to);
        check_cnt++; if (to !== 1'b0 || n_req !== 1 || got !== 32'h11111111) $display("FAIL conf_ld1: got req %0d data %h want 1/11111111", n_req, got); else pass_cnt++;
        check_cnt++; if (miss_cnt !== 16'd3) $display("FAIL conf_miss1: got %0d want 3", miss_cnt); else pass_cnt++;
        access(1'b0, 16'h0440, 32'h0, 0, 32'h22222222, n_stall, n_req, got, s_we, s_addr, s_wdata, to);
        check_cnt++; if (to !== 1'b0 || n_req !== 1 || s_addr !== 16'h0440) $display("FAIL conf_ld2_req: got %0d/%h want 1/0440", n_req, s_addr); else pass_cnt++;
        check_cnt++; if (got !== 32'h22222222) $display("FAIL conf_ld2_rdata: got %h want 22222222", got); else pass_cnt++;
        check_cnt++; if (miss_cnt !== 16'd4) $display("FAIL conf_miss2: got %0d want 4", miss_cnt); else pass_cnt++;
        access(1'b0, 16'h0040, 32'h0, 0, 32'h33333333, n_stall, n_req, got, s_we, s_addr, s_wdata, to);
        check_cnt++; if (to !== 1'b0 || n_stall !== 2 || got !== 32'h33333333) $display("FAIL conf_ld3: got stall %0d data %h want 2/33333333", n_stall, got); else pass_cnt++;
        check_cnt++; if (miss_cnt !== 16'd5 || hit_cnt !== 16'd7) $display("FAIL conf_cnts: got %0d/%0d want 5/7", miss_cnt, hit_cnt); else pass_cnt++;
    endtask

    task automatic test_flush();
        access(1'b0, 16'h0040, 32'h0, 0, 32'hFFFFFFFF, n_stall, n_req, got, s_we, s_addr, s_wdata, to);
        check_cnt++; if (to !== 1'b0 || n_stall !== 0 || got !== 32'h33333333) $display("FAIL flush_prehit: got %0d/%h want 0/33333333", n_stall, got); else pass_cnt++;
        flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        #1;
        check_cnt++; if (stall !== 1'b1) $display("FAIL flush_stall: got %b want 1", stall); else pass_cnt++;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_cnt++; if (cpu_rdata !== 32'h0) $display("FAIL flush_invalid: got %h want 0", cpu_rdata); else pass_cnt++;
        check_cnt++; if (hit_cnt !== 16'd8) $display("FAIL flush_no_count: got %0d want 8", hit_cnt); else pass_cnt++;
        access(1'b0, 16'h0040, 32'h0, 0, 32'h44444444, n_stall, n_req, got, s_we, s_addr, s_wdata, to);
        check_cnt++; if (to !== 1'b0 || n_stall !== 2 || n_req !== 1) $display("FAIL flush_then_miss: got stall %0d req %0d want 2/1", n_stall, n_req); else pass_cnt++;
        check_cnt++; if (got !== 32'h44444444 || miss_cnt !== 16'd6) $display("FAIL flush_refill: got %h/%0d want 44444444/6", got, miss_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_in_rmiss();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0240;
        @(negedge clk);
        #1;
        check_cnt++; if (mem_req !== 1'b1 || stall !== 1'b1) $display("FAIL rmiss_entered: got req %b stall %b want 1/1", mem_req, stall); else pass_cnt++;
        #2;
        rst = 1'b0;
        cpu_req = 1'b0;
        #1;
        check_cnt++; if (mem_req !== 1'b0) $display("FAIL arst_mem_req: got %b want 0", mem_req); else pass_cnt++;
        check_cnt++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) $display("FAIL arst_cnts: got %0d/%0d want 0/0", hit_cnt, miss_cnt); else pass_cnt++;
        check_cnt++; if (stall !== 1'b0) $display("FAIL arst_stall: got %b want 0", stall); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        cpu_addr = 16'h0040;
        #1;
        check_cnt++; if (cpu_rdata !== 32'h0) $display("FAIL arst_invalid: got %h want 0", cpu_rdata); else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_load_hit();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_flush();
        test_reset_in_rmiss();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
